// File: rtl/pipe_buffer_chain.sv
// pipe_buffer_chain: parametrised chain of STAGES pipeline registers with a
// valid bit each. Each stage can be stalled or flushed. A bubble is inserted
// below a held stage. An optional collapse mode lets a bubble be overwritten
// while the stages below it are held. Two saturating counters track retired
// entries and inserted bubbles.
module pipe_buffer_chain #(
  parameter int WIDTH    = 64,
  parameter int STAGES   = 4,
  parameter int COLLAPSE = 0,
  parameter int CNT_W    = 16
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [WIDTH-1:0]          In,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [STAGES-1:0]         Stall,
  input  logic [STAGES-1:0]         Flush,
  output logic [STAGES*WIDTH-1:0]   StageData,
  output logic [STAGES-1:0]         StageValid,
  output logic [WIDTH-1:0]          Out,
  output logic                      OutValid,
  output logic [CNT_W-1:0]          RetireCount,
  output logic [CNT_W-1:0]          BubbleCount
);

  // Stage registers and their next-state values.
  logic [STAGES-1:0][WIDTH-1:0] data_r;
  logic [STAGES-1:0][WIDTH-1:0] data_nxt_s;
  logic [STAGES-1:0]            valid_r;
  logic [STAGES-1:0]            valid_nxt_s;

  // Effective hold per stage, and the values seen from the stage above.
  logic [STAGES-1:0]            hold_s;
  logic [STAGES-1:0]            up_hold_s;
  logic [STAGES-1:0][WIDTH-1:0] up_data_s;
  logic [STAGES-1:0]            up_valid_s;
  logic [WIDTH-1:0]             in_data_s;

  // Bubble insertions and retirement for this cycle.
  logic [STAGES-1:0]            ins_s;
  logic [CNT_W-1:0]             bubble_n_s;
  logic                         retire_s;
  logic [CNT_W-1:0]             retire_r;
  logic [CNT_W-1:0]             bubble_r;

  // Add two counter values and clamp at all-ones so the result never wraps.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Invalid input is loaded as all-zero data so bubbles are always clean.
  always_comb begin
    if (InValid) begin
      in_data_s = In;
    end else begin
      in_data_s = {WIDTH{1'b0}};
    end
  end

  // Propagate holds upstream. In collapse mode a bubble stage breaks the chain.
  // A scalar carries the running value, so the loop never reads hold_s back.
  always_comb begin
    logic h;
    hold_s            = {STAGES{1'b0}};
    h                 = Stall[STAGES-1];
    hold_s[STAGES-1]  = h;
    for (int k = STAGES - 2; k >= 0; k--) begin
      if (COLLAPSE != 0) begin
        h = Stall[k] | (h & valid_r[k]);
      end else begin
        h = Stall[k] | h;
      end
      hold_s[k] = h;
    end
  end

  // Stage k sees stage k-1 above it. Stage 0 sees the input, and the input is
  // never held, so stage 0 never takes a bubble.
  assign up_data_s  = {data_r[STAGES-2:0], in_data_s};
  assign up_valid_s = {valid_r[STAGES-2:0], InValid};
  assign up_hold_s  = {hold_s[STAGES-2:0], 1'b0};

  // Per-stage update. Flush beats hold, hold beats bubble insertion, and
  // bubble insertion beats a normal shift.
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    ins_s       = {STAGES{1'b0}};
    bubble_n_s  = {CNT_W{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      if (Flush[k]) begin
        data_nxt_s[k]  = {WIDTH{1'b0}};
        valid_nxt_s[k] = 1'b0;
      end else if (hold_s[k]) begin
        data_nxt_s[k]  = data_r[k];
        valid_nxt_s[k] = valid_r[k];
      end else if (up_hold_s[k]) begin
        data_nxt_s[k]  = {WIDTH{1'b0}};
        valid_nxt_s[k] = 1'b0;
        ins_s[k]       = 1'b1;
      end else begin
        data_nxt_s[k]  = up_data_s[k];
        valid_nxt_s[k] = up_valid_s[k];
      end
      bubble_n_s = bubble_n_s + {{(CNT_W-1){1'b0}}, ins_s[k]};
    end
  end

  // An entry retires when it leaves the last stage without being stalled or flushed.
  assign retire_s = valid_r[STAGES-1] & ~Stall[STAGES-1] & ~Flush[STAGES-1];

  // Stage registers and counters. Reset clears everything and overrides stall/flush.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_r   <= {(STAGES*WIDTH){1'b0}};
      valid_r  <= {STAGES{1'b0}};
      retire_r <= {CNT_W{1'b0}};
      bubble_r <= {CNT_W{1'b0}};
    end else begin
      data_r   <= data_nxt_s;
      valid_r  <= valid_nxt_s;
      if (retire_s) begin
        retire_r <= sat_add(retire_r, {{(CNT_W-1){1'b0}}, 1'b1});
      end else begin
        retire_r <= retire_r;
      end
      bubble_r <= sat_add(bubble_r, bubble_n_s);
    end
  end

  assign StageData   = data_r;
  assign StageValid  = valid_r;
  assign Out         = data_r[STAGES-1];
  assign OutValid    = valid_r[STAGES-1];
  assign RetireCount = retire_r;
  assign BubbleCount = bubble_r;
  assign InReady     = ~hold_s[0];

endmodule

// File: tb/tb_pipe_buffer_chain.sv
// Directed bench for pipe_buffer_chain. Instance a uses the non-collapsing
// chain and instance b uses collapse mode. Both have STAGES=4, WIDTH=16 and
// CNT_W=4, and both receive the same stimulus.
module tb_pipe_buffer_chain;

  logic        Clk;
  logic        Rst;
  logic [15:0] In;
  logic        InValid;
  logic [3:0]  Stall;
  logic [3:0]  Flush;

  logic        a_ready, b_ready;
  logic [63:0] a_sd, b_sd;
  logic [3:0]  a_sv, b_sv;
  logic [15:0] a_out, b_out;
  logic        a_ov, b_ov;
  logic [3:0]  a_ret, b_ret, a_bub, b_bub;

  int errors = 0;
  int checks = 0;

  pipe_buffer_chain #(.WIDTH(16), .STAGES(4), .COLLAPSE(0), .CNT_W(4)) dut_a (
    .Clk(Clk), .Rst(Rst), .In(In), .InValid(InValid), .InReady(a_ready),
    .Stall(Stall), .Flush(Flush), .StageData(a_sd), .StageValid(a_sv),
    .Out(a_out), .OutValid(a_ov), .RetireCount(a_ret), .BubbleCount(a_bub)
  );

  pipe_buffer_chain #(.WIDTH(16), .STAGES(4), .COLLAPSE(1), .CNT_W(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .In(In), .InValid(InValid), .InReady(b_ready),
    .Stall(Stall), .Flush(Flush), .StageData(b_sd), .StageValid(b_sv),
    .Out(b_out), .OutValid(b_ov), .RetireCount(b_ret), .BubbleCount(b_bub)
  );

  // Free-running clock with a 10-unit period.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One rising edge, then settle before outputs are sampled.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed stimulus with hand-computed expectations.
  initial begin
    Rst = 1'b1; In = 16'h0; InValid = 1'b0; Stall = 4'h0; Flush = 4'h0;
    step();
    Rst = 1'b0;
    chk("rst_valid_a", a_sv, 4'h0);
    chk("rst_data_a", a_sd, 64'h0);
    chk("rst_ret_a", a_ret, 4'd0);
    chk("rst_bub_a", a_bub, 4'd0);
    chk("rst_valid_b", b_sv, 4'h0);
    chk("rst_ready_a", a_ready, 1'b1);

    // Stream 1..6. The first value reaches Out after the 4th edge.
    for (int n = 1; n <= 10; n++) begin
      In      = (n <= 6) ? 16'(n) : 16'h0;
      InValid = (n <= 6);
      step();
      chk("stream_out", a_out, (n >= 4 && n <= 9) ? 64'(n - 3) : 64'h0);
      chk("stream_ov", a_ov, (n >= 4 && n <= 9) ? 64'h1 : 64'h0);
    end
    chk("stream_ret", a_ret, 4'd6);
    chk("stream_bub", a_bub, 4'd0);

    // Fill so that reg3..reg0 = D,C,B,A, then stall stage 2 for two cycles.
    InValid = 1'b1;
    In = 16'h00D0; step();
    In = 16'h00C0; step();
    In = 16'h00B0; step();
    In = 16'h00A0; step();
    chk("fill_data", a_sd, 64'h00D0_00C0_00B0_00A0);
    chk("fill_ret", a_ret, 4'd6);
    Stall = 4'b0100; In = 16'h00E0;
    #1;
    chk("stall_ready", a_ready, 1'b0);
    step();
    chk("stall1_valid", a_sv, 4'b0111);
    chk("stall1_out", a_out, 16'h0);
    chk("stall1_ret", a_ret, 4'd7);
    chk("stall1_bub", a_bub, 4'd1);
    step();
    chk("stall2_bub", a_bub, 4'd2);
    chk("stall2_data", a_sd, 64'h0000_00C0_00B0_00A0);
    chk("stall2_ret", a_ret, 4'd7);
    Stall = 4'b0000;
    step();
    InValid = 1'b0; In = 16'h0;
    chk("resume_out0", a_out, 16'h00C0);
    step(); chk("resume_out1", a_out, 16'h00B0);
    step(); chk("resume_out2", a_out, 16'h00A0);
    step(); chk("resume_out3", a_out, 16'h00E0);
    step(); chk("resume_ov4", a_ov, 1'b0);
    chk("resume_ret", a_ret, 4'd11);

    // Jump: flush reg0/reg1. Reg1's entry still shifts into reg2 on that edge.
    InValid = 1'b1;
    In = 16'h0011; step();
    In = 16'h0010; step();
    chk("jump_pre_valid", a_sv, 4'b0011);
    InValid = 1'b0; In = 16'h0; Flush = 4'b0011;
    step();
    Flush = 4'b0000;
    chk("jump_valid", a_sv, 4'b0100);
    chk("jump_low", a_sd[31:0], 32'h0);
    chk("jump_reg2", a_sd[47:32], 16'h0011);
    step();
    chk("jump_out", a_out, 16'h0011);
    step();
    chk("jump_ov", a_ov, 1'b0);
    chk("jump_ret", a_ret, 4'd12);
    chk("jump_bub", a_bub, 4'd2);

    // Hole at reg1 with the last stage stalled: only collapse mode fills it.
    InValid = 1'b1;
    In = 16'h0031; step();
    In = 16'h0032; step();
    InValid = 1'b0; In = 16'h0; step();
    InValid = 1'b1; In = 16'h0034; step();
    chk("hole_valid_a", a_sv, 4'b1101);
    chk("hole_valid_b", b_sv, 4'b1101);
    Stall = 4'b1000; In = 16'h0035;
    #1;
    chk("hole_ready_a", a_ready, 1'b0);
    chk("hole_ready_b", b_ready, 1'b1);
    step();
    chk("coll0_data_a", a_sd, 64'h0031_0032_0000_0034);
    chk("coll0_valid_a", a_sv, 4'b1101);
    chk("coll1_data_b", b_sd, 64'h0031_0032_0034_0035);
    chk("coll1_valid_b", b_sv, 4'b1111);
    chk("coll1_ready_b", b_ready, 1'b0);
    chk("coll_bub_a", a_bub, 4'd2);
    chk("coll_bub_b", b_bub, 4'd2);
    chk("coll_ret_b", b_ret, 4'd12);
    Stall = 4'b0000; InValid = 1'b0; In = 16'h0;
    for (int i = 0; i < 4; i++) step();
    chk("drain_ret_a", a_ret, 4'd15);
    chk("drain_ret_b", b_ret, 4'd15);

    // Keep retiring while the counter is already at its maximum.
    InValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      In = 16'h0040 + 16'(i);
      step();
      chk("sat_ret", a_ret, 4'd15);
    end
    chk("sat_out", a_out, 16'h0050);

    // Reset mid-stream with every stage stalled.
    Rst = 1'b1; Stall = 4'hF;
    step();
    Rst = 1'b0; Stall = 4'h0; InValid = 1'b0; In = 16'h0;
    chk("mrst_valid_a", a_sv, 4'h0);
    chk("mrst_data_a", a_sd, 64'h0);
    chk("mrst_ret_a", a_ret, 4'd0);
    chk("mrst_bub_a", a_bub, 4'd0);
    chk("mrst_valid_b", b_sv, 4'h0);
    chk("mrst_ret_b", b_ret, 4'd0);

    // Stall and flush together on the last stage while it holds a valid entry.
    InValid = 1'b1;
    In = 16'h0051; step();
    In = 16'h0052; step();
    In = 16'h0053; step();
    In = 16'h0054; step();
    chk("sf_fill_out", a_out, 16'h0051);
    Stall = 4'b1000; Flush = 4'b1000; In = 16'h0055;
    #1;
    chk("sf_ready", a_ready, 1'b0);
    step();
    Stall = 4'b0000; Flush = 4'b0000; InValid = 1'b0; In = 16'h0;
    chk("sf_valid", a_sv, 4'b0111);
    chk("sf_out", a_out, 16'h0);
    chk("sf_ret", a_ret, 4'd0);
    chk("sf_bub", a_bub, 4'd0);
    chk("sf_held", a_sd[47:0], 48'h0052_0053_0054);
    step();
    chk("sf_next_out", a_out, 16'h0052);
    chk("sf_next_ret", a_ret, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
